tmds_word_serializer: RTL and testbench



---
 rtl/tmds_word_serializer_if.sv | 24 ++
 rtl/tmds_word_serializer.sv | 70 +++++++
 tb/tb_tmds_word_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tmds_word_serializer_if.sv
// Character/stream bundle between the upstream TMDS encoder and the 10:1 serializer.
// master: upstream side (presents characters); slave: serializer side.
interface tmds_word_serializer_if #(
    parameter int unsigned WORD_W = 10
);
    logic [WORD_W-1:0] parallelIn;
    logic              loadStrobe;
    logic              serialOut;
    logic [3:0]        onesCount;

    modport master (
        output parallelIn,
        input  loadStrobe,
        input  serialOut,
        input  onesCount
    );

    modport slave (
        input  parallelIn,
        output loadStrobe,
        output serialOut,
        output onesCount
    );
endinterface

// File: rtl/tmds_word_serializer.sv
// 10:1 TMDS character serializer running on the serial clock, with a combinational
// popcount of the low POP_W character bits for the upstream encoder.
// Build option: define OSER_MSB_FIRST_EN to send the character MSB first
// (default is LSB first, D0..D9).
module tmds_word_serializer #(
    parameter int unsigned WORD_W = 10,
    parameter int unsigned POP_W  = 8
) (
    input  logic                    serialClock,
    input  logic                    reset,
    tmds_word_serializer_if.slave   ser_if
);
    localparam logic [3:0] LastBit = 4'(WORD_W - 1);

    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              ser_out_q, ser_out_d;
    logic              load;
    logic [3:0]        nxt_idx;
    logic [3:0]        ones;

    // Load decision and next-state for counter, holding register and serial bit.
    always_comb begin
        load      = (bit_cnt_q == LastBit) && !reset;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        ser_out_d = ser_out_q;
`ifdef OSER_MSB_FIRST_EN
        // Stream position bit_cnt_q+1 maps to character bit WORD_W-2-bit_cnt_q.
        nxt_idx = 4'(WORD_W - 2) - bit_cnt_q;
`else
        nxt_idx = bit_cnt_q + 4'd1;
`endif
        if (reset) begin
            bit_cnt_d = LastBit;
            hold_d    = '0;
            ser_out_d = 1'b0;
        end else if (load) begin
            bit_cnt_d = 4'd0;
            hold_d    = ser_if.parallelIn;
`ifdef OSER_MSB_FIRST_EN
            ser_out_d = ser_if.parallelIn[WORD_W-1];
`else
            ser_out_d = ser_if.parallelIn[0];
`endif
        end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            ser_out_d = hold_q[nxt_idx];
        end
    end

    // State registers; reset is handled synchronously in the next-state logic.
    always_ff @(posedge serialClock) begin
        bit_cnt_q <= bit_cnt_d;
        hold_q    <= hold_d;
        ser_out_q <= ser_out_d;
    end

    // Popcount of the low character bits; independent of clock and reset.
    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < int'(POP_W); i++) begin
            ones = ones + 4'(ser_if.parallelIn[i]);
        end
    end

    assign ser_if.loadStrobe = load;
    assign ser_if.serialOut  = ser_out_q;
    assign ser_if.onesCount  = ones;
endmodule

// File: tb/tb_tmds_word_serializer.sv
// Directed bench for tmds_word_serializer: stream order, load cadence, input
// sampling only on load edges, mid-word reset and the popcount output.
module tb_tmds_word_serializer;
    logic serialClock = 1'b0;
    logic reset       = 1'b1;
    int   n_pass      = 0;
    int   n_total     = 0;

    tmds_word_serializer_if #(.WORD_W(10)) sif ();

    tmds_word_serializer #(
        .WORD_W (10),
        .POP_W  (8)
    ) dut (
        .serialClock (serialClock),
        .reset       (reset),
        .ser_if      (sif)
    );

    always #5 serialClock = ~serialClock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bit k of the serial stream for character w.
    function automatic logic exp_bit(input logic [9:0] w, input int k);
`ifdef OSER_MSB_FIRST_EN
        return w[9-k];
`else
        return w[k];
`endif
    endfunction

    task automatic tick();
        @(posedge serialClock);
        #1;
    endtask

    // Called with loadStrobe expected high; presents w and checks the next 10 bits.
    // With scramble set, parallelIn is overwritten on every non-load cycle.
    task automatic send_word(input string tag, input logic [9:0] w, input bit scramble);
        check_eq({tag, "_strobe_at_load"}, 32'(sif.loadStrobe), 32'd1);
        sif.parallelIn = w;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq($sformatf("%s_bit%0d", tag, k), 32'(sif.serialOut), 32'(exp_bit(w, k)));
            check_eq($sformatf("%s_strobe%0d", tag, k), 32'(sif.loadStrobe), 32'(k == 9));
            if (scramble && k < 9) sif.parallelIn = 10'($urandom);
        end
    endtask

    initial begin
        logic [9:0] w;
        int         ref_cnt;
        sif.parallelIn = 10'h000;

        // Reset state.
        tick();
        tick();
        check_eq("rst_serial", 32'(sif.serialOut), 32'd0);
        check_eq("rst_strobe", 32'(sif.loadStrobe), 32'd0);

        // Popcount sweep; upper two bits must not matter.
        check_eq("pop_00", 32'(sif.onesCount), 32'd0);
        for (int v = 0; v < 256; v++) begin
            for (int hi = 0; hi < 4; hi++) begin
                w = {2'(hi), 8'(v)};
                ref_cnt = 0;
                for (int b = 0; b < 8; b++) ref_cnt += (v >> b) & 1;
                sif.parallelIn = w;
                #1;
                check_eq($sformatf("pop_%03h", w), 32'(sif.onesCount), 32'(ref_cnt));
            end
        end
        sif.parallelIn = 10'h0FF;
        #1;
        check_eq("pop_ff", 32'(sif.onesCount), 32'd8);

        // Release reset: strobe rises immediately, first edge loads.
        @(negedge serialClock);
        reset = 1'b0;
        #1;
        check_eq("strobe_after_release", 32'(sif.loadStrobe), 32'd1);
        send_word("t1a", 10'b1101010100, 1'b0);
        send_word("t1b", 10'b1101010100, 1'b0);

        // Back-to-back all ones / all zeros.
        send_word("t2a", 10'h3FF, 1'b0);
        send_word("t2b", 10'h000, 1'b0);

        // Inputs changing off load edges must be ignored.
        send_word("t3a", 10'h2C5, 1'b1);
        send_word("t3b", 10'h13A, 1'b1);

        // Reset while bit 4 of a word is on the pin.
        check_eq("t4_strobe_at_load", 32'(sif.loadStrobe), 32'd1);
        sif.parallelIn = 10'h3FF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("t4_bit%0d", k), 32'(sif.serialOut), 32'd1);
        end
        reset = 1'b1;
        #1;
        check_eq("t4_strobe_in_reset", 32'(sif.loadStrobe), 32'd0);
        tick();
        check_eq("t4_serial_after_rst", 32'(sif.serialOut), 32'd0);
        check_eq("t4_strobe_rst_hold", 32'(sif.loadStrobe), 32'd0);
        tick();
        check_eq("t4_serial_rst2", 32'(sif.serialOut), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("t4_strobe_release", 32'(sif.loadStrobe), 32'd1);
        send_word("t4_fresh", 10'h2A9, 1'b0);

        // Bit-order words; expectations follow the build option.
        send_word("t6a", 10'b1000000001, 1'b0);
        send_word("t6b", 10'b0000000011, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
